clk_rate_detect: RTL and testbench
==================================

CLK_RATE_DETECT -- requirements
Module: clk_rate_detect

Interface
REQ-001 SHALL have parameter FS48_CNT, default 256, nominal mclk cycles per ws frame at hz48.
REQ-002 SHALL have parameter FS44_CNT, default 279, nominal mclk cycles per ws frame at hz44.
REQ-003 SHALL have parameter TOL, default 4, allowed +/- deviation in mclk cycles.
REQ-004 SHALL have parameter LOCK_CNT, default 4, consecutive matching frames required for lock.
REQ-005 SHALL have port mclk  input  1  block clock; all logic on posedge mclk.
REQ-006 SHALL have port rst_  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port en  input  1  detector enable, synchronous to mclk.
REQ-008 SHALL have port sclk_in  input  1  external I2S bit clock, asynchronous to mclk.
REQ-009 SHALL have port ws_in  input  1  external I2S word select, asynchronous to mclk.
REQ-010 SHALL have port sclk_rise  output  1  one-cycle strobe per synchronized sclk rising edge.
REQ-011 SHALL have port sclk_fall  output  1  one-cycle strobe per synchronized sclk falling edge.
REQ-012 SHALL have port locked  output  1  rate and frame size stable and valid.
REQ-013 SHALL have port rate_hz48  output  1  detected sample rate: 1 = hz48, 0 = hz44.
REQ-014 SHALL have port frame32  output  1  detected frame size: 1 = f32bits, 0 = f16bits per channel.
REQ-015 SHALL have port err  output  1  one-cycle strobe on lock loss or timeout.

Function
REQ-016 SHALL synchronize sclk_in and ws_in through two flops each, then edge-detect; sclk_rise/sclk_fall SHALL assert exactly 3 mclk cycles after the first mclk edge that samples the new input level.
REQ-017 SHALL support sclk_in frequency up to mclk/4; faster input is out of scope.
REQ-018 SHALL implement states IDLE, SYNC, MEASURE, LOCKED; en=0 in any state forces IDLE next cycle, clears counters and locked.
REQ-019 IDLE -> SYNC when en=1; SYNC -> MEASURE on first synchronized ws rising edge, clearing cnt_m and cnt_s.
REQ-020 In MEASURE/LOCKED, cnt_m (10-bit) SHALL increment every mclk, cnt_s (7-bit) on each sclk_rise; both saturate and clear at each ws rising edge.
REQ-021 At each ws rising edge the frame SHALL be valid if cnt_s is 32 or 64 and cnt_m is within FS48_CNT+/-TOL or FS44_CNT+/-TOL (inclusive); class = {rate, cnt_s==64}.
REQ-022 A frame SHALL match if valid and its class equals the previous frame's class; match_cnt increments on match, resets to 1 on valid non-match, to 0 on invalid.
REQ-023 MEASURE -> LOCKED when match_cnt reaches LOCK_CNT-1 matches after the first valid frame (LOCK_CNT valid identical frames); locked, rate_hz48, frame32 update in the same cycle.
REQ-024 In LOCKED, a non-matching frame SHALL pulse err one cycle, drop locked the same cycle, enter MEASURE with that frame as new reference; rate_hz48/frame32 hold last locked values.
REQ-025 ws rising edge and sclk_rise in the same cycle: the sclk edge SHALL count in the closing frame.

Reset
REQ-026 rst_ low SHALL immediately force IDLE, counters 0, sclk_rise=0, sclk_fall=0, locked=0, rate_hz48=0, frame32=0, err=0, sync flops 0.
REQ-027 Reset mid-lock SHALL discard all measurement; relock requires full REQ-019..REQ-023 sequence.

Configuration
REQ-028 Macro CLK_RATE_DET_TIMEOUT_EN defined: cnt_m reaching 1023 in MEASURE/LOCKED SHALL pulse err, clear locked, enter SYNC; undefined: cnt_m saturates silently, no timeout.

Verification
REQ-029 ws period 256 mclk, 64 sclk rises/frame -> locked=1 at 4th frame-closing ws edge after the SYNC edge, rate_hz48=1, frame32=1.
REQ-030 ws period 279 mclk, 32 sclk rises/frame -> locked=1, rate_hz48=0, frame32=0.
REQ-031 locked at 256/64, inject one 300-mclk frame -> err one cycle, locked=0; 4 further good frames -> relock.
REQ-032 With CLK_RATE_DET_TIMEOUT_EN, ws_in held constant while locked -> err when cnt_m hits 1023, state SYNC; without macro, no err.
REQ-033 rst_ pulsed low mid-frame while locked -> all outputs 0 immediately; relock after SYNC edge plus 4 frames.
REQ-034 en dropped for 1 cycle while locked -> locked=0 next cycle, no err pulse.

Source files
------------

// File: rtl/clk_rate_detect.sv
// I2S sample-rate / frame-size detector: measures ws period in mclk cycles and sclk edges per frame.
// Optional `CLK_RATE_DET_TIMEOUT_EN: a frame stretching to 1023 mclk raises err and restarts from SYNC.
module clk_rate_detect #(
    parameter int FS48_CNT = 256,
    parameter int FS44_CNT = 279,
    parameter int TOL      = 4,
    parameter int LOCK_CNT = 4
) (
    input  logic mclk,
    input  logic rst_,
    input  logic en,
    input  logic sclk_in,
    input  logic ws_in,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic locked,
    output logic rate_hz48,
    output logic frame32,
    output logic err
);

    typedef enum logic [1:0] {IDLE, SYNC, MEASURE, LOCKED} state_t;

    localparam logic [9:0] CNT_M_MAX = '1;
    localparam logic [6:0] CNT_S_MAX = '1;

    state_t      state;
    logic [3:0]  sclk_sr, ws_sr;
    logic        ws_rise;
    logic [9:0]  cnt_m;
    logic [6:0]  cnt_s;
    logic [7:0]  match_cnt;
    logic [1:0]  ref_class;

    logic [10:0] m_len;
    logic [7:0]  s_len;
    logic        in48, in44, s32, s64, fr_valid, fr_match;
    logic [1:0]  fr_class;
    logic [7:0]  match_nxt;

    // [1:0] resynchronize, [2] is the settled level, [3] its history; strobes are registered
    always_ff @(posedge mclk or negedge rst_) begin
        if (!rst_) begin
            sclk_sr   <= '0;
            ws_sr     <= '0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ws_rise   <= 1'b0;
        end else begin
            sclk_sr   <= {sclk_sr[2:0], sclk_in};
            ws_sr     <= {ws_sr[2:0], ws_in};
            sclk_rise <= sclk_sr[2] & ~sclk_sr[3];
            sclk_fall <= ~sclk_sr[2] & sclk_sr[3];
            ws_rise   <= ws_sr[2] & ~ws_sr[3];
        end
    end

    // Frame evaluation; an sclk edge coincident with the closing ws edge belongs to this frame
    always_comb begin
        m_len    = {1'b0, cnt_m} + 11'd1;
        s_len    = {1'b0, cnt_s} + {7'd0, sclk_rise};
        in48     = (int'(m_len) >= FS48_CNT - TOL) && (int'(m_len) <= FS48_CNT + TOL);
        in44     = (int'(m_len) >= FS44_CNT - TOL) && (int'(m_len) <= FS44_CNT + TOL);
        s32      = (s_len == 8'd32);
        s64      = (s_len == 8'd64);
        fr_valid = (s32 || s64) && (in48 || in44);
        fr_class = {in48, s64};
        fr_match = fr_valid && (match_cnt != 8'd0) && (fr_class == ref_class);
        if (!fr_valid)
            match_nxt = 8'd0;
        else if (fr_match)
            match_nxt = (match_cnt == 8'hFF) ? match_cnt : match_cnt + 8'd1;
        else
            match_nxt = 8'd1;
    end

    always_ff @(posedge mclk or negedge rst_) begin
        if (!rst_) begin
            state     <= IDLE;
            cnt_m     <= '0;
            cnt_s     <= '0;
            match_cnt <= '0;
            ref_class <= '0;
            locked    <= 1'b0;
            rate_hz48 <= 1'b0;
            frame32   <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            if (!en) begin
                state     <= IDLE;
                cnt_m     <= '0;
                cnt_s     <= '0;
                match_cnt <= '0;
                locked    <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= SYNC;
                    SYNC: if (ws_rise) begin
                        state     <= MEASURE;
                        cnt_m     <= '0;
                        cnt_s     <= '0;
                        match_cnt <= '0;
                    end
                    default: begin
                        if (ws_rise) begin
                            cnt_m     <= '0;
                            cnt_s     <= '0;
                            match_cnt <= match_nxt;
                            ref_class <= fr_class;
                            if (state == LOCKED) begin
                                // Mismatching frame becomes the new reference
                                if (!fr_match) begin
                                    err    <= 1'b1;
                                    locked <= 1'b0;
                                    state  <= MEASURE;
                                end
                            end else if (int'(match_nxt) >= LOCK_CNT) begin
                                locked    <= 1'b1;
                                rate_hz48 <= fr_class[1];
                                frame32   <= fr_class[0];
                                state     <= LOCKED;
                            end
                        end
`ifdef CLK_RATE_DET_TIMEOUT_EN
                        else if (cnt_m == CNT_M_MAX) begin
                            err       <= 1'b1;
                            locked    <= 1'b0;
                            state     <= SYNC;
                            cnt_m     <= '0;
                            cnt_s     <= '0;
                            match_cnt <= '0;
                        end
`endif
                        else begin
                            if (cnt_m != CNT_M_MAX) cnt_m <= cnt_m + 10'd1;
                            if (sclk_rise && cnt_s != CNT_S_MAX) cnt_s <= cnt_s + 7'd1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_rate_detect.sv
// Directed bench for clk_rate_detect: edge latency, lock at both rates, frame errors, reset/enable.
// Follows `CLK_RATE_DET_TIMEOUT_EN to choose the timeout expectation.
module tb_clk_rate_detect;

    logic mclk = 1'b0;
    logic rst_ = 1'b0;
    logic en = 1'b0;
    logic sclk_in = 1'b0;
    logic ws_in = 1'b0;
    logic sclk_rise, sclk_fall, locked, rate_hz48, frame32, err;

    int errors = 0;
    int checks = 0;
    int err_cnt = 0;
    int rise_cnt = 0;
    bit err_wide = 1'b0;
    bit err_lock_bad = 1'b0;
    logic err_d = 1'b0;

    clk_rate_detect dut (
        .mclk(mclk), .rst_(rst_), .en(en), .sclk_in(sclk_in), .ws_in(ws_in),
        .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .locked(locked),
        .rate_hz48(rate_hz48), .frame32(frame32), .err(err)
    );

    always #5 mclk = ~mclk;

    always @(negedge mclk) begin
        if (err === 1'b1) begin
            err_cnt++;
            if (locked !== 1'b0) err_lock_bad = 1'b1;
            if (err_d === 1'b1) err_wide = 1'b1;
        end
        err_d = err;
        if (sclk_rise === 1'b1) rise_cnt++;
    end

    // One ws frame of n mclk: ws high first half, k sclk bits of 4 mclk (low,low,high,high).
    // hi0 drives sclk high in cycle 0 so its rising edge lands with the ws rising edge.
    task automatic frame(input int n, input int k, input bit hi0);
        for (int c = 0; c < n; c++) begin
            @(negedge mclk);
            ws_in   = (c < n / 2);
            sclk_in = (c == 0) ? hi0 : ((c < 4 * k) && ((c % 4) >= 2));
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge mclk);
            ws_in   = 1'b0;
            sclk_in = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst_ = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge mclk);
            sclk_in = i[0];
            ws_in   = i[1];
        end
        #1;
        checks++; if (sclk_rise !== 1'b0) begin errors++; $display("FAIL reset_sclk_rise: got %b want 0", sclk_rise); end
        checks++; if (sclk_fall !== 1'b0) begin errors++; $display("FAIL reset_sclk_fall: got %b want 0", sclk_fall); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (rate_hz48 !== 1'b0) begin errors++; $display("FAIL reset_rate: got %b want 0", rate_hz48); end
        checks++; if (frame32 !== 1'b0) begin errors++; $display("FAIL reset_frame32: got %b want 0", frame32); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        idle(2);
        rst_ = 1'b1;
        idle(4);
    endtask

    // New level sampled at edge 0; strobe must be visible only after edge 3
    task automatic test_edge_latency;
        logic [4:0] r, f;
        @(negedge mclk);
        sclk_in = 1'b1;
        for (int e = 0; e < 5; e++) begin
            @(posedge mclk); #1;
            r[e] = sclk_rise;
            f[e] = sclk_fall;
        end
        checks++; if (r !== 5'b01000) begin errors++; $display("FAIL rise_latency: got %b want 01000", r); end
        checks++; if (f !== 5'b00000) begin errors++; $display("FAIL no_fall_on_rise: got %b want 00000", f); end
        @(negedge mclk);
        sclk_in = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(posedge mclk); #1;
            r[e] = sclk_rise;
            f[e] = sclk_fall;
        end
        checks++; if (f !== 5'b01000) begin errors++; $display("FAIL fall_latency: got %b want 01000", f); end
        checks++; if (r !== 5'b00000) begin errors++; $display("FAIL no_rise_on_fall: got %b want 00000", r); end
    endtask

    task automatic test_lock48;
        int e0, r1;
        en = 1'b1;
        idle(8);
        e0 = err_cnt;
        for (int i = 0; i < 4; i++) frame(256, 64, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock48_early: got %b want 0", locked); end
        r1 = rise_cnt;
        frame(256, 64, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock48_locked: got %b want 1", locked); end
        checks++; if (rate_hz48 !== 1'b1) begin errors++; $display("FAIL lock48_rate: got %b want 1", rate_hz48); end
        checks++; if (frame32 !== 1'b1) begin errors++; $display("FAIL lock48_frame32: got %b want 1", frame32); end
        checks++; if (rise_cnt - r1 != 64) begin errors++; $display("FAIL lock48_rises: got %0d want 64", rise_cnt - r1); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL lock48_err: got %0d want %0d", err_cnt, e0); end
    endtask

    task automatic test_coincident;
        int e0;
        e0 = err_cnt;
        frame(256, 63, 1'b0);
        frame(256, 64, 1'b1);
        frame(256, 64, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL coincident_locked: got %b want 1", locked); end
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL coincident_err: got %0d want %0d", err_cnt, e0); end
    endtask

    task automatic test_bad_frame;
        int e0;
        e0 = err_cnt;
        frame(300, 64, 1'b0);
        frame(256, 64, 1'b0);
        checks++; if (err_cnt != e0 + 1) begin errors++; $display("FAIL bad_err_count: got %0d want %0d", err_cnt, e0 + 1); end
        checks++; if (err_wide !== 1'b0) begin errors++; $display("FAIL bad_err_width: got %b want 0", err_wide); end
        checks++; if (err_lock_bad !== 1'b0) begin errors++; $display("FAIL bad_err_with_lock: got %b want 0", err_lock_bad); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL bad_locked: got %b want 0", locked); end
        checks++; if (rate_hz48 !== 1'b1 || frame32 !== 1'b1) begin errors++; $display("FAIL bad_hold: got %b%b want 11", rate_hz48, frame32); end
        for (int i = 0; i < 3; i++) frame(256, 64, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: got %b want 0", locked); end
        frame(256, 64, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock: got %b want 1", locked); end
    endtask

    task automatic test_en_drop;
        int e0;
        e0 = err_cnt;
        @(negedge mclk);
        en = 1'b0;
        @(posedge mclk); #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL en_drop_locked: got %b want 0", locked); end
        @(negedge mclk);
        en = 1'b1;
        idle(8);
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL en_drop_err: got %0d want %0d", err_cnt, e0); end
    endtask

    task automatic test_lock44;
        idle(4);
        for (int i = 0; i < 4; i++) frame(279, 32, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock44_early: got %b want 0", locked); end
        frame(279, 32, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock44_locked: got %b want 1", locked); end
        checks++; if (rate_hz48 !== 1'b0) begin errors++; $display("FAIL lock44_rate: got %b want 0", rate_hz48); end
        checks++; if (frame32 !== 1'b0) begin errors++; $display("FAIL lock44_frame32: got %b want 0", frame32); end
    endtask

    task automatic test_rst_mid;
        frame(120, 30, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rst_pre_locked: got %b want 1", locked); end
        #2 rst_ = 1'b0;
        #1;
        checks++; if ({sclk_rise, sclk_fall, locked, rate_hz48, frame32, err} !== 6'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %b want 000000", {sclk_rise, sclk_fall, locked, rate_hz48, frame32, err});
        end
        @(negedge mclk);
        rst_ = 1'b1;
        idle(8);
        for (int i = 0; i < 4; i++) frame(279, 32, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_relock_early: got %b want 0", locked); end
        frame(279, 32, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rst_relock: got %b want 1", locked); end
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        idle(1100);
`ifdef CLK_RATE_DET_TIMEOUT_EN
        checks++; if (err_cnt != e0 + 1) begin errors++; $display("FAIL timeout_err: got %0d want %0d", err_cnt, e0 + 1); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL timeout_locked: got %b want 0", locked); end
`else
        checks++; if (err_cnt != e0) begin errors++; $display("FAIL timeout_err: got %0d want %0d", err_cnt, e0); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL timeout_locked: got %b want 1", locked); end
`endif
        checks++; if (err_wide !== 1'b0) begin errors++; $display("FAIL err_width_overall: got %b want 0", err_wide); end
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_lock48();
        test_coincident();
        test_bad_frame();
        test_en_drop();
        test_lock44();
        test_rst_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
